// File: rtl/pio_hit_sim_if.sv
// pio_hit_sim_if
// Groups the PIO command word and the hit/status outputs of pio_hit_sim.
//   cmd_in    : 32-bit PIO export word ([31] toggle, [30:28] opcode, [27:0] data)
//   hit_out   : NUM_CH simulated hit pulses
//   hit_start : one-cycle strobe on the first high cycle of each pulse
//   busy      : a pulse train is active
//   hit_count : pulses emitted since the last START or SINGLE
//   cmd_ack   : toggle bit of the last accepted command
// The master modport is the HPS/software side; the slave modport is the generator.
interface pio_hit_sim_if #(
    parameter int unsigned NUM_CH = 8
);
    logic [31:0]       cmd_in;
    logic [NUM_CH-1:0] hit_out;
    logic              hit_start;
    logic              busy;
    logic [15:0]       hit_count;
    logic              cmd_ack;

    modport master (
        output cmd_in,
        input  hit_out, hit_start, busy, hit_count, cmd_ack
    );

    modport slave (
        input  cmd_in,
        output hit_out, hit_start, busy, hit_count, cmd_ack
    );
endinterface

// File: rtl/pio_hit_sim.sv
// pio_hit_sim
// Decodes toggle-strobed commands from the HPS PIO word and generates
// programmable simulated detector hit pulses.
//   clk_clk     : system clock (shared with the PIO, so no synchronisers)
//   reset_reset : synchronous, active-high reset
//   bus         : pio_hit_sim_if.slave (cmd_in in; hit_out, hit_start, busy,
//                 hit_count, cmd_ack out)
module pio_hit_sim #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned PERIOD_W = 20
) (
    input  logic          clk_clk,
    input  logic          reset_reset,
    pio_hit_sim_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET_MASK   = 3'd1,
        OP_SET_PERIOD = 3'd2,
        OP_SET_COUNT  = 3'd3,
        OP_START      = 3'd4,
        OP_STOP       = 3'd5,
        OP_SINGLE     = 3'd6,
        OP_RSVD       = 3'd7
    } opcode_t;

    localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_W - 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_W + 1);
    localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(16);

    state_t              state_q,     state_d;
    logic [31:0]         cmd_q,       cmd_d;
    logic                last_tog_q,  last_tog_d;
    logic [NUM_CH-1:0]   chan_mask_q, chan_mask_d;
    logic [PERIOD_W-1:0] period_q,    period_d;
    logic [15:0]         count_cfg_q, count_cfg_d;
    // Shadow copies are what the running train actually uses; they are only
    // refreshed at a pulse start so config writes never disturb a period.
    logic [NUM_CH-1:0]   mask_sh_q,   mask_sh_d;
    logic [PERIOD_W-1:0] period_sh_q, period_sh_d;
    logic [PERIOD_W-1:0] cyc_q,       cyc_d;
    logic [15:0]         remain_q,    remain_d;
    logic [15:0]         hit_count_q, hit_count_d;

    logic                accept;
    opcode_t             opcode;
    logic [27:0]         data;
    logic                unused_data;

    assign accept      = (cmd_q[31] != last_tog_q);
    assign opcode      = opcode_t'(cmd_q[30:28]);
    assign data        = cmd_q[27:0];
    assign unused_data = ^data;

    always_comb begin
        cmd_d       = bus.cmd_in;
        last_tog_d  = last_tog_q;
        chan_mask_d = chan_mask_q;
        period_d    = period_q;
        count_cfg_d = count_cfg_q;
        state_d     = state_q;
        mask_sh_d   = mask_sh_q;
        period_sh_d = period_sh_q;
        cyc_d       = cyc_q;
        remain_d    = remain_q;
        hit_count_d = hit_count_q;

        // Configuration registers update on acceptance regardless of state.
        if (accept) begin
            last_tog_d = cmd_q[31];
            case (opcode)
                OP_SET_MASK:   chan_mask_d = data[NUM_CH-1:0];
                OP_SET_PERIOD: period_d = (data[PERIOD_W-1:0] < MIN_PERIOD) ?
                                          MIN_PERIOD : data[PERIOD_W-1:0];
                OP_SET_COUNT:  count_cfg_d = data[15:0];
                default:       ;
            endcase
        end

        if (accept && opcode == OP_STOP) begin
            state_d = ST_IDLE;
            cyc_d   = '0;
        end else if (accept && (opcode == OP_START ||
                                (opcode == OP_SINGLE && state_q == ST_IDLE))) begin
            // hit_count reads 1 during the first pulse cycle, i.e. the
            // clear and the first increment happen together.
            state_d     = ST_PULSE;
            cyc_d       = '0;
            mask_sh_d   = chan_mask_d;
            period_sh_d = period_d;
            remain_d    = (opcode == OP_START) ? count_cfg_d : 16'd1;
            hit_count_d = 16'd1;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    cyc_d = cyc_q + PERIOD_W'(1);
                    if (cyc_q == PULSE_LAST) begin
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cyc_q == period_sh_q - PERIOD_W'(1)) begin
                        cyc_d = '0;
                        if (remain_q == 16'd1) begin
                            state_d = ST_IDLE;
                        end else begin
                            // remain_q == 0 marks a continuous run.
                            if (remain_q != 16'd0) begin
                                remain_d = remain_q - 16'd1;
                            end
                            state_d     = ST_PULSE;
                            mask_sh_d   = chan_mask_d;
                            period_sh_d = period_d;
                            hit_count_d = (hit_count_q == 16'hFFFF) ?
                                          hit_count_q : hit_count_q + 16'd1;
                        end
                    end else begin
                        cyc_d = cyc_q + PERIOD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            last_tog_q  <= 1'b0;
            chan_mask_q <= '1;
            period_q    <= RST_PERIOD;
            count_cfg_q <= '0;
            mask_sh_q   <= '1;
            period_sh_q <= RST_PERIOD;
            cyc_q       <= '0;
            remain_q    <= '0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            last_tog_q  <= last_tog_d;
            chan_mask_q <= chan_mask_d;
            period_q    <= period_d;
            count_cfg_q <= count_cfg_d;
            mask_sh_q   <= mask_sh_d;
            period_sh_q <= period_sh_d;
            cyc_q       <= cyc_d;
            remain_q    <= remain_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign bus.hit_out   = (state_q == ST_PULSE) ? mask_sh_q : '0;
    assign bus.hit_start = (state_q == ST_PULSE) && (cyc_q == '0);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.hit_count = hit_count_q;
    assign bus.cmd_ack   = last_tog_q;

endmodule
